pwm_scheduler: RTL

//  Turns the SPI-written configuration (output enables, PWM enables, duty) into 16 driven

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_prescaler.sv | 36 +++
 rtl/pwm_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the PWM scheduler slice: channel count, last period
//   step, FSM state encoding and the duty comparison used by the output stage.
package pwm_pkg;

    localparam int         N_CH    = 16;
    localparam logic [7:0] PER_MAX = 8'd254;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_t;

    // PWM level for one period step. The period counter stops at 254, so a
    // duty of 0xFF stays high through the wrap and 0x00 never goes high.
    function automatic logic pwm_level(input logic [7:0] per_cnt,
                                       input logic [7:0] duty_sh);
        return per_cnt < duty_sh;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler
//   Divides clk by PRESCALE. tick is high for one cycle when the counter sits
//   on its last value, and the counter restarts from zero on that cycle.
//   A high clear forces the counter to zero and suppresses tick.
// Ports
//   clk    in  system clock
//   rst    in  synchronous reset, active-high
//   clear  in  hold the counter at zero
//   tick   out one-cycle pulse every PRESCALE counting cycles
module pwm_prescaler #(
    parameter int PRESCALE = 3000,
    parameter int PRE_W    = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = !clear && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clear || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_scheduler.sv
// pwm_scheduler
//   Drives 16 output pins from the SPI configuration. Enabled channels are
//   static high unless their PWM bit is set, in which case they follow an
//   8-bit duty over a 255-step period of PRESCALE clk cycles per step. Duty
//   and PWM-select are shadowed and reloaded only at period boundaries so a
//   write never produces a runt pulse. The counters idle whenever no enabled
//   channel asks for PWM.
// Ports
//   clk           in  system clock
//   rst           in  synchronous reset, active-high
//   en_out        in  [15:0] channel drive enable, applied on the next edge
//   en_pwm        in  [15:0] 1 = PWM, 0 = static high; shadowed per period
//   duty          in  [7:0]  high steps per period; shadowed per period
//   pwm_out       out [15:0] registered pin levels
//   period_start  out one-cycle pulse after the shadows were loaded
//   running       out high while the FSM is in RUN
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no channel needs PWM; counters held at zero, pins static
// ST_RUN  | period counter advancing, PWM channels follow the shadows
module pwm_scheduler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 3000,
    parameter int PRE_W    = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] en_out,
    input  logic [N_CH-1:0] en_pwm,
    input  logic [7:0]      duty,
    output logic [N_CH-1:0] pwm_out,
    output logic            period_start,
    output logic            running
);

    pwm_state_t      state;
    logic [7:0]      per_cnt;
    logic [7:0]      duty_sh;
    logic [N_CH-1:0] pwm_sh;

    logic            need;
    logic            tick;
    logic            pre_clear;
    logic            level;
    logic [N_CH-1:0] pwm_next;

    assign need = |(en_out & en_pwm);

    // Counting only happens in RUN with demand; leaving RUN restarts the
    // prescaler from zero so the next period is full length.
    assign pre_clear = (state != ST_RUN) || !need;

    pwm_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (pre_clear),
        .tick  (tick)
    );

    // Output stage works from the current state and shadows; en_out is live,
    // so disabling a pin takes effect one edge later regardless of phase.
    always_comb begin
        level    = pwm_level(per_cnt, duty_sh);
        pwm_next = en_out;
        if (state == ST_RUN) begin
            pwm_next = en_out & (~pwm_sh | {N_CH{level}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            per_cnt      <= '0;
            duty_sh      <= '0;
            pwm_sh       <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            running      <= 1'b0;
        end else begin
            pwm_out      <= pwm_next;
            period_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    per_cnt <= '0;
                    if (need) begin
                        state        <= ST_RUN;
                        running      <= 1'b1;
                        duty_sh      <= duty;
                        pwm_sh       <= en_pwm;
                        period_start <= 1'b1;
                    end else begin
                        running <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Losing demand wins over a coincident wrap: no reload.
                    if (!need) begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                        per_cnt <= '0;
                    end else begin
                        running <= 1'b1;
                        if (tick) begin
                            if (per_cnt == PER_MAX) begin
                                per_cnt      <= '0;
                                duty_sh      <= duty;
                                pwm_sh       <= en_pwm;
                                period_start <= 1'b1;
                            end else begin
                                per_cnt <= per_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    per_cnt <= '0;
                end
            endcase
        end
    end

endmodule
